// File: rtl/wmem_multibank_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | drlp_wmem_pkg: shared sizing constants and clog2 helper for the       |
// | multi-bank weights memory.             Revision: 1.0                  |
// +-----------------------------------------------------------------------+
package drlp_wmem_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int p = 1; p < value; p = p * 2) begin
         r++;
      end
      return r;
   endfunction

   localparam int DEPTH         = 2 ** 7;
   localparam int BANK_WIDTH    = clog2(2);
   localparam int ROW_WGT_WIDTH = 8 * 6;

endpackage
`default_nettype wire

// File: rtl/wmem_multibank_bank_ram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wmem_bank_ram: one weight bank, synchronous write, enabled registered |
// | read (output holds when not read).     Revision: 1.0                  |
// +-----------------------------------------------------------------------+
module wmem_bank_ram
   import drlp_wmem_pkg::*;
#(
   parameter int WIDTH      = 48,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [WIDTH-1:0]      i_wdata,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [WIDTH-1:0]      o_rdata
);

   logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         o_rdata <= mem_q[i_raddr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/wmem_multibank.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wmem_multibank: ring of weight banks; loader fills the write bank     |
// | while the PE array reads and releases the oldest full bank. Rev 1.0   |
// +-----------------------------------------------------------------------+
module wmem_multibank
   import drlp_wmem_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ROW_NUM       = 6,
   parameter int ADDR_WIDTH    = 7,
   parameter int NUM_BANK      = 2,
   parameter int BANK_WIDTH    = clog2(NUM_BANK),
   parameter int ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_wr_vld,
   output logic                     o_wr_rdy,
   input  logic [ROW_WGT_WIDTH-1:0] i_wr_data,
   input  logic                     i_wr_last,
   input  logic                     i_rd_en,
   input  logic [ADDR_WIDTH-1:0]    i_rd_addr,
   output logic [ROW_WGT_WIDTH-1:0] o_rd_data,
   output logic                     o_rd_valid,
   input  logic                     i_rd_release,
   output logic                     o_rd_bank_vld,
   output logic [BANK_WIDTH-1:0]    o_rd_bank_id,
   output logic [BANK_WIDTH:0]      o_full_cnt
);

   logic [BANK_WIDTH-1:0]    wr_bank_q, wr_bank_d;
   logic [BANK_WIDTH-1:0]    rd_bank_q, rd_bank_d;
   logic [BANK_WIDTH-1:0]    rd_sel_q;
   logic [ADDR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
   logic [NUM_BANK-1:0]      full_q, full_d;
   logic [BANK_WIDTH:0]      cnt_q, cnt_d;
   logic                     rd_valid_q;
   logic                     rd_seen_q;
   logic                     w_wr_acc, w_close, w_rd_ok, w_rel;
   logic [ROW_WGT_WIDTH-1:0] w_bank_rdata [NUM_BANK];

   // Ready depends only on registered flags, so a release never reaches it combinationally.
   assign o_wr_rdy      = ~full_q[wr_bank_q];
   assign o_rd_bank_vld = full_q[rd_bank_q];
   assign o_rd_bank_id  = rd_bank_q;
   assign o_full_cnt    = cnt_q;
   assign o_rd_valid    = rd_valid_q;

   assign w_wr_acc = i_wr_vld & o_wr_rdy;
   assign w_close  = w_wr_acc & (i_wr_last | (&wr_ptr_q));
   assign w_rd_ok  = i_rd_en & o_rd_bank_vld;
   assign w_rel    = i_rd_release & o_rd_bank_vld;

   always_comb begin
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_ptr_d  = wr_ptr_q;
      full_d    = full_q;
      cnt_d     = cnt_q;
      if (w_wr_acc) begin
         wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (w_close) begin
         full_d[wr_bank_q] = 1'b1;
         wr_ptr_d          = '0;
         wr_bank_d         = wr_bank_q + BANK_WIDTH'(1);
      end
      if (w_rel) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = rd_bank_q + BANK_WIDTH'(1);
      end
      if (w_close && !w_rel) begin
         cnt_d = cnt_q + (BANK_WIDTH+1)'(1);
      end else if (w_rel && !w_close) begin
         cnt_d = cnt_q - (BANK_WIDTH+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_bank_q  <= '0;
         rd_bank_q  <= '0;
         rd_sel_q   <= '0;
         wr_ptr_q   <= '0;
         full_q     <= '0;
         cnt_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_seen_q  <= 1'b0;
      end else begin
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         wr_ptr_q   <= wr_ptr_d;
         full_q     <= full_d;
         cnt_q      <= cnt_d;
         rd_valid_q <= w_rd_ok;
         // Remember the bank a read came from so a same-cycle release cannot redirect it.
         if (w_rd_ok) begin
            rd_sel_q  <= rd_bank_q;
            rd_seen_q <= 1'b1;
         end
      end
   end

   for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
      wmem_bank_ram #(
         .WIDTH      (ROW_WGT_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_ram (
         .i_clk   (i_clk),
         .i_we    (w_wr_acc && (wr_bank_q == BANK_WIDTH'(b))),
         .i_waddr (wr_ptr_q),
         .i_wdata (i_wr_data),
         .i_re    (w_rd_ok && (rd_bank_q == BANK_WIDTH'(b))),
         .i_raddr (i_rd_addr),
         .o_rdata (w_bank_rdata[b])
      );
   end

   // Bank output registers are not reset; mask them until a read has actually happened.
   assign o_rd_data = rd_seen_q ? w_bank_rdata[rd_sel_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_wmem_multibank.sv
`default_nettype none
// Directed bench for wmem_multibank: reference model tracks flags/pointers,
// read results flow through an expected-data queue.
module tb_wmem_multibank;

   localparam int DW    = 8;
   localparam int RN    = 6;
   localparam int AW    = 7;
   localparam int NB    = 2;
   localparam int BW    = 1;
   localparam int RW    = DW * RN;
   localparam int DEPTH = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_vld;
   logic          wr_rdy;
   logic [RW-1:0] wr_data;
   logic          wr_last;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [RW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_release;
   logic          rd_bank_vld;
   logic [BW-1:0] rd_bank_id;
   logic [BW:0]   full_cnt;

   wmem_multibank #(
      .DATA_WIDTH (DW),
      .ROW_NUM    (RN),
      .ADDR_WIDTH (AW),
      .NUM_BANK   (NB)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_wr_vld      (wr_vld),
      .o_wr_rdy      (wr_rdy),
      .i_wr_data     (wr_data),
      .i_wr_last     (wr_last),
      .i_rd_en       (rd_en),
      .i_rd_addr     (rd_addr),
      .o_rd_data     (rd_data),
      .o_rd_valid    (rd_valid),
      .i_rd_release  (rd_release),
      .o_rd_bank_vld (rd_bank_vld),
      .o_rd_bank_id  (rd_bank_id),
      .o_full_cnt    (full_cnt)
   );

   always #5 clk = ~clk;

   int            n_vec = 0;
   int            n_err = 0;
   logic [RW-1:0] exp_q [$];
   logic [RW-1:0] mon_e;

   logic [RW-1:0] m_mem [NB][DEPTH];
   logic          m_full [NB];
   int            m_wb, m_rb, m_wp;
   logic [RW-1:0] m_last;
   logic          m_vld;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every valid read beat must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL rd_spurious: observed valid data %0h expected no read", rd_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rd_data", 64'(rd_data), 64'(mon_e));
         end
      end
   end

   task automatic tick(input logic r, input logic wv, input logic [RW-1:0] wd, input logic wl,
                       input logic re, input logic [AW-1:0] ra, input logic rl);
      logic acc, cls, rok, rlo;
      int   cnt;
      rst = r; wr_vld = wv; wr_data = wd; wr_last = wl;
      rd_en = re; rd_addr = ra; rd_release = rl;
      acc = !r && wv && !m_full[m_wb];
      cls = acc && (wl || m_wp == DEPTH - 1);
      rok = !r && re && m_full[m_rb];
      rlo = !r && rl && m_full[m_rb];
      if (rok) exp_q.push_back(m_mem[m_rb][ra]);
      @(posedge clk);
      #1;
      if (r) begin
         for (int b = 0; b < NB; b++) m_full[b] = 1'b0;
         m_wb = 0; m_rb = 0; m_wp = 0; m_last = '0; m_vld = 1'b0;
         exp_q.delete();
      end else begin
         m_vld = rok;
         if (rok) m_last = m_mem[m_rb][ra];
         if (acc) begin
            m_mem[m_wb][m_wp] = wd;
            m_wp++;
         end
         if (cls) begin
            m_full[m_wb] = 1'b1;
            m_wp = 0;
            m_wb = (m_wb + 1) % NB;
         end
         if (rlo) begin
            m_full[m_rb] = 1'b0;
            m_rb = (m_rb + 1) % NB;
         end
      end
      cnt = 0;
      for (int b = 0; b < NB; b++) cnt += int'(m_full[b]);
      chk("wr_rdy", 64'(wr_rdy), 64'(!m_full[m_wb]));
      chk("rd_bank_vld", 64'(rd_bank_vld), 64'(m_full[m_rb]));
      chk("rd_bank_id", 64'(rd_bank_id), 64'(m_rb));
      chk("full_cnt", 64'(full_cnt), 64'(cnt));
      chk("rd_valid", 64'(rd_valid), 64'(m_vld));
      if (!m_vld) chk("rd_hold", 64'(rd_data), 64'(m_last));
   endtask

   task automatic idle();                                tick(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0); endtask
   task automatic wr(input logic [RW-1:0] d, input logic l); tick(1'b0, 1'b1, d, l, 1'b0, '0, 1'b0); endtask
   task automatic rd(input logic [AW-1:0] a);              tick(1'b0, 1'b0, '0, 1'b0, 1'b1, a, 1'b0); endtask
   task automatic rel();                                 tick(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1); endtask

   initial begin
      rst = 1'b1; wr_vld = 1'b0; wr_data = '0; wr_last = 1'b0;
      rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
      m_wb = 0; m_rb = 0; m_wp = 0; m_last = '0; m_vld = 1'b0;
      for (int b = 0; b < NB; b++) m_full[b] = 1'b0;

      tick(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      tick(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      chk("reset_wr_rdy", 64'(wr_rdy), 64'd1);
      chk("reset_bank_vld", 64'(rd_bank_vld), 64'd0);
      chk("reset_full_cnt", 64'(full_cnt), 64'd0);
      chk("reset_rd_valid", 64'(rd_valid), 64'd0);
      chk("reset_rd_data", 64'(rd_data), 64'd0);
      idle();
      rd(AW'(5));
      chk("idle_read_ignored", 64'(rd_valid), 64'd0);

      // Short load closed by last, then back-to-back reads.
      for (int i = 0; i < 4; i++) wr(RW'(48'h0A + i), i == 3);
      chk("load_bank_id", 64'(rd_bank_id), 64'd0);
      chk("load_full_cnt", 64'(full_cnt), 64'd1);
      for (int i = 0; i < 4; i++) begin
         rd(AW'(i));
         chk("load_rd_now", 64'(rd_data), 64'(48'h0A + i));
      end
      idle();

      // Fill the second bank; further beats stall until a release.
      wr(RW'(48'h1111), 1'b0);
      wr(RW'(48'h2222), 1'b1);
      chk("both_full_cnt", 64'(full_cnt), 64'd2);
      chk("both_full_rdy", 64'(wr_rdy), 64'd0);
      wr(RW'(48'hEEEE), 1'b1);
      chk("stall_full_cnt", 64'(full_cnt), 64'd2);
      rel();
      chk("rel_wr_rdy", 64'(wr_rdy), 64'd1);
      chk("rel_bank_id", 64'(rd_bank_id), 64'd1);
      chk("rel_full_cnt", 64'(full_cnt), 64'd1);
      rd(AW'(0));
      rd(AW'(1));
      rel();
      idle();

      // 128 beats without last: auto-close at the last row, next beat goes to bank 1.
      for (int i = 0; i < DEPTH; i++) wr(RW'(48'h100 + i), 1'b0);
      chk("autoclose_full_cnt", 64'(full_cnt), 64'd1);
      chk("autoclose_wr_rdy", 64'(wr_rdy), 64'd1);
      wr(RW'(48'hABC), 1'b1);
      chk("beat129_full_cnt", 64'(full_cnt), 64'd2);
      rd(AW'(0));
      rd(AW'(127));
      tick(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(64), 1'b1);
      chk("rd_with_rel_data", 64'(rd_data), 64'(48'h140));
      chk("rd_with_rel_bank_id", 64'(rd_bank_id), 64'd1);
      rd(AW'(0));
      chk("beat129_row0", 64'(rd_data), 64'(48'hABC));

      // Close bank 0 while releasing bank 1 in the same cycle.
      wr(RW'(48'h3131), 1'b0);
      tick(1'b0, 1'b1, RW'(48'h3232), 1'b1, 1'b0, '0, 1'b1);
      chk("cr_full_cnt", 64'(full_cnt), 64'd1);
      chk("cr_bank_id", 64'(rd_bank_id), 64'd0);
      chk("cr_wr_rdy", 64'(wr_rdy), 64'd1);
      rd(AW'(0));
      rd(AW'(1));
      idle();

      // Reset in the middle of a partial load.
      for (int i = 0; i < 3; i++) wr(RW'(48'h500 + i), 1'b0);
      tick(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      chk("midrst_wr_rdy", 64'(wr_rdy), 64'd1);
      chk("midrst_bank_vld", 64'(rd_bank_vld), 64'd0);
      chk("midrst_full_cnt", 64'(full_cnt), 64'd0);
      chk("midrst_bank_id", 64'(rd_bank_id), 64'd0);
      wr(RW'(48'h77), 1'b1);
      rd(AW'(0));
      chk("midrst_row0", 64'(rd_data), 64'(48'h77));
      idle();
      idle();

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
